// File: rtl/countdown_ctrl_if.sv
// Control/status bundle for the countdown sequencer: load/start/hold/reload
// requests in, count and run flags out.
interface countdown_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             hold;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load, load_val, start, hold, auto_reload,
    input  count, busy, tc, done
  );

  modport slave (
    input  load, load_val, start, hold, auto_reload,
    output count, busy, tc, done
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Countdown sequencer driving a ripple full-adder decrementer (count + all-ones).
// Supports pause, terminal-count pulse and optional auto-reload.
module cd_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module countdown_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  countdown_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic             tc_q, tc_nxt;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] dec;
  logic [WIDTH:0]   carry;
  logic             count_nz, is_one, reload_nz;

  // count + all-ones: the dropped carry-out is 1 exactly when count != 0,
  // so it doubles as the non-zero flag.
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    cd_fa u_fa (
      .a   (count_q[i]),
      .b   (1'b1),
      .cin (carry[i]),
      .s   (dec[i]),
      .cout(carry[i+1])
    );
  end

  assign count_nz  = carry[WIDTH];
  assign is_one    = (count_q == WIDTH'(1));
  assign reload_nz = |reload_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
      tc_q     <= tc_nxt;
      busy_q   <= (state_nxt == RUN) || (state_nxt == PAUSE);
      done_q   <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.load) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = count_nz ? RUN : DONE;
        RUN:     if (bus.hold) state_nxt = PAUSE;
                 else if (is_one && !bus.auto_reload) state_nxt = DONE;
        PAUSE:   if (!bus.hold) state_nxt = RUN;
        DONE:    if (bus.start && reload_nz) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    count_nxt  = count_q;
    reload_nxt = reload_q;
    tc_nxt     = 1'b0;
    if (bus.load) begin
      count_nxt  = bus.load_val;
      reload_nxt = bus.load_val;
    end else begin
      case (state)
        IDLE: if (bus.start && !count_nz) tc_nxt = 1'b1;
        RUN: if (!bus.hold) begin
          if (is_one) begin
            tc_nxt    = 1'b1;
            count_nxt = bus.auto_reload ? reload_q : '0;
          end else if (count_nz) count_nxt = dec;
        end
        DONE: if (bus.start) begin
          if (reload_nz) count_nxt = reload_q;
          else           tc_nxt    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;
endmodule
